// File: rtl/mouse_pkg.sv
// Shared constants and FSM encoding for the mouse position tracker.
// PS/2 status byte bit positions, overflow counter width and tracker states.
package mouse_pkg;

   localparam int XSIGN = 4;
   localparam int YSIGN = 5;
   localparam int XOVF  = 6;
   localparam int YOVF  = 7;

   localparam int OVF_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      UPDATE = 2'd2,
      EMIT   = 2'd3
   } state_t;

endpackage

// File: rtl/mouse_axis_update.sv
// One coordinate axis: builds the scaled/saturated delta from the packet fields and
// produces the next position, either clamped to 0..LIMIT-1 or wrapped modulo LIMIT.
module mouse_axis_update #(
   parameter int COORD_W = 10,
   parameter int LIMIT   = 640,
   parameter int SHIFT   = 0,
   parameter int WRAP    = 0,
   parameter int INVERT  = 0
) (
   input  logic [7:0]         mag_i,
   input  logic               sign_i,
   input  logic               ovf_i,
   output logic [COORD_W+2:0] delta_o,
   input  logic [COORD_W-1:0] pos_i,
   input  logic [COORD_W+2:0] delta_i,
   output logic [COORD_W-1:0] pos_o
);

   localparam int DW = COORD_W + 3;
   localparam int SW = COORD_W + 4;
   localparam logic signed [SW-1:0] LIM_S   = SW'(LIMIT);
   localparam logic signed [SW-1:0] MAX_S   = SW'(LIMIT - 1);
   localparam logic [COORD_W-1:0]   LIMIT_C = COORD_W'(LIMIT);
   localparam logic [COORD_W-1:0]   MAX_C   = COORD_W'(LIMIT - 1);

   logic [8:0]         raw_s;
   logic [DW-1:0]      scaled_s;
   logic signed [SW-1:0] sum_s;

   // Delta: overflow saturates to -256/+255, then scale and optional inversion.
   // Width carries one spare bit so negating a fully scaled -256 cannot overflow.
   always_comb begin
      raw_s = {sign_i, mag_i};
      if (ovf_i) begin
         raw_s = sign_i ? 9'h100 : 9'h0FF;
      end else begin
         raw_s = {sign_i, mag_i};
      end
      scaled_s = {{(DW-9){raw_s[8]}}, raw_s} << SHIFT;
      if (INVERT != 0) begin
         delta_o = -scaled_s;
      end else begin
         delta_o = scaled_s;
      end
   end

   // Position: signed sum, then clamp or single-step wrap (|delta| < LIMIT when wrapping).
   always_comb begin
      sum_s = {{(SW-COORD_W){1'b0}}, pos_i} + {delta_i[DW-1], delta_i};
      pos_o = sum_s[COORD_W-1:0];
      if (WRAP != 0) begin
         if (sum_s[SW-1]) begin
            pos_o = sum_s[COORD_W-1:0] + LIMIT_C;
         end else if (sum_s >= LIM_S) begin
            pos_o = sum_s[COORD_W-1:0] - LIMIT_C;
         end else begin
            pos_o = sum_s[COORD_W-1:0];
         end
      end else begin
         if (sum_s[SW-1]) begin
            pos_o = {COORD_W{1'b0}};
         end else if (sum_s > MAX_S) begin
            pos_o = MAX_C;
         end else begin
            pos_o = sum_s[COORD_W-1:0];
         end
      end
   end

endmodule

// File: rtl/mouse_position_tracker.sv
// Accumulates PS/2 movement packets into a screen position with buttons and overflow count.
// Optional wheel accumulator is built only when MOUSE_WHEEL_EN is defined.
module mouse_position_tracker
   import mouse_pkg::*;
#(
   parameter int COORD_W  = 10,
   parameter int LIMIT_X  = 640,
   parameter int LIMIT_Y  = 480,
   parameter int SHIFT    = 0,
   parameter int WRAP     = 0,
   parameter int INVERT_Y = 1
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               PKT_VALID,
   output logic               PKT_READY,
   input  logic [7:0]         PKT_STATUS,
   input  logic [7:0]         PKT_DX,
   input  logic [7:0]         PKT_DY,
`ifdef MOUSE_WHEEL_EN
   input  logic [3:0]         PKT_DZ,
   output logic [7:0]         WHEEL_POS,
`endif
   input  logic               SET_POS,
   input  logic [COORD_W-1:0] SET_X,
   input  logic [COORD_W-1:0] SET_Y,
   output logic [COORD_W-1:0] POS_X,
   output logic [COORD_W-1:0] POS_Y,
   output logic [2:0]         BUTTONS,
   output logic [2:0]         BTN_CHANGE,
   output logic               POS_VALID,
   output logic [OVF_W-1:0]   OVF_COUNT
);

   localparam int DW = COORD_W + 3;
   localparam logic [COORD_W-1:0] HOME_X = COORD_W'(LIMIT_X / 2);
   localparam logic [COORD_W-1:0] HOME_Y = COORD_W'(LIMIT_Y / 2);
   localparam logic [COORD_W-1:0] MAX_X  = COORD_W'(LIMIT_X - 1);
   localparam logic [COORD_W-1:0] MAX_Y  = COORD_W'(LIMIT_Y - 1);

   state_t             state_q, state_d;
   logic [7:4]         flags_q, flags_d;
   logic [2:0]         pbtn_q, pbtn_d;
   logic [7:0]         dx_q, dx_d, dy_q, dy_d;
   logic [DW-1:0]      dlx_q, dlx_d, dly_q, dly_d;
   logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [2:0]         btn_q, btn_d, chg_q, chg_d;
   logic               valid_q, valid_d;
   logic [OVF_W-1:0]   ovf_q, ovf_d;
   logic               pkt_ready_s;
   logic [DW-1:0]      dx_delta_s, dy_delta_s;
   logic [COORD_W-1:0] new_x_s, new_y_s;
   logic               unused_status_s;

`ifdef MOUSE_WHEEL_EN
   logic [3:0]         dz_q, dz_d;
   logic [7:0]         wheel_q, wheel_d;
   logic [8:0]         wheel_sum_s;
`endif

   assign unused_status_s = PKT_STATUS[3];

   mouse_axis_update #(
      .COORD_W(COORD_W), .LIMIT(LIMIT_X), .SHIFT(SHIFT), .WRAP(WRAP), .INVERT(0)
   ) u_axis_x (
      .mag_i(dx_q), .sign_i(flags_q[XSIGN]), .ovf_i(flags_q[XOVF]), .delta_o(dx_delta_s),
      .pos_i(pos_x_q), .delta_i(dlx_q), .pos_o(new_x_s)
   );

   mouse_axis_update #(
      .COORD_W(COORD_W), .LIMIT(LIMIT_Y), .SHIFT(SHIFT), .WRAP(WRAP), .INVERT(INVERT_Y)
   ) u_axis_y (
      .mag_i(dy_q), .sign_i(flags_q[YSIGN]), .ovf_i(flags_q[YOVF]), .delta_o(dy_delta_s),
      .pos_i(pos_y_q), .delta_i(dly_q), .pos_o(new_y_s)
   );

   // Next-state and datapath control for the IDLE/CALC/UPDATE/EMIT sequence.
   always_comb begin
      state_d     = state_q;
      pkt_ready_s = 1'b0;
      flags_d     = flags_q;
      pbtn_d      = pbtn_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      dlx_d       = dlx_q;
      dly_d       = dly_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      btn_d       = btn_q;
      chg_d       = chg_q;
      ovf_d       = ovf_q;
`ifdef MOUSE_WHEEL_EN
      dz_d        = dz_q;
      wheel_d     = wheel_q;
      wheel_sum_s = {{5{dz_q[3]}}, dz_q} + {wheel_q[7], wheel_q};
`endif
      case (state_q)
         IDLE: begin
            pkt_ready_s = ~SET_POS;
            if (SET_POS) begin
               pos_x_d = (SET_X > MAX_X) ? MAX_X : SET_X;
               pos_y_d = (SET_Y > MAX_Y) ? MAX_Y : SET_Y;
               chg_d   = 3'b000;
               state_d = EMIT;
            end else if (PKT_VALID) begin
               flags_d = PKT_STATUS[7:4];
               pbtn_d  = PKT_STATUS[2:0];
               dx_d    = PKT_DX;
               dy_d    = PKT_DY;
`ifdef MOUSE_WHEEL_EN
               dz_d    = PKT_DZ;
`endif
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            dlx_d   = dx_delta_s;
            dly_d   = dy_delta_s;
            state_d = UPDATE;
         end
         UPDATE: begin
            pos_x_d = new_x_s;
            pos_y_d = new_y_s;
            btn_d   = pbtn_q;
            chg_d   = btn_q ^ pbtn_q;
            if ((flags_q[XOVF] | flags_q[YOVF]) && (ovf_q != {OVF_W{1'b1}})) begin
               ovf_d = ovf_q + {{(OVF_W-1){1'b0}}, 1'b1};
            end else begin
               ovf_d = ovf_q;
            end
`ifdef MOUSE_WHEEL_EN
            if (wheel_sum_s[8] != wheel_sum_s[7]) begin
               wheel_d = wheel_sum_s[8] ? 8'h80 : 8'h7F;
            end else begin
               wheel_d = wheel_sum_s[7:0];
            end
`endif
            state_d = EMIT;
         end
         EMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      valid_d = (state_d == EMIT);
   end

   // State and output registers; reset discards any packet in flight.
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state_q <= IDLE;
         flags_q <= 4'h0;
         pbtn_q  <= 3'b000;
         dx_q    <= 8'h00;
         dy_q    <= 8'h00;
         dlx_q   <= {DW{1'b0}};
         dly_q   <= {DW{1'b0}};
         pos_x_q <= HOME_X;
         pos_y_q <= HOME_Y;
         btn_q   <= 3'b000;
         chg_q   <= 3'b000;
         valid_q <= 1'b0;
         ovf_q   <= {OVF_W{1'b0}};
`ifdef MOUSE_WHEEL_EN
         dz_q    <= 4'h0;
         wheel_q <= 8'h00;
`endif
      end else begin
         state_q <= state_d;
         flags_q <= flags_d;
         pbtn_q  <= pbtn_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         dlx_q   <= dlx_d;
         dly_q   <= dly_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         btn_q   <= btn_d;
         chg_q   <= chg_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
`ifdef MOUSE_WHEEL_EN
         dz_q    <= dz_d;
         wheel_q <= wheel_d;
`endif
      end
   end

   assign PKT_READY  = pkt_ready_s;
   assign POS_X      = pos_x_q;
   assign POS_Y      = pos_y_q;
   assign BUTTONS    = btn_q;
   assign BTN_CHANGE = chg_q;
   assign POS_VALID  = valid_q;
   assign OVF_COUNT  = ovf_q;
`ifdef MOUSE_WHEEL_EN
   assign WHEEL_POS  = wheel_q;
`endif

endmodule

// File: tb/tb_mouse_position_tracker.sv
// Scoreboard bench: a clamping instance (0) and a wrapping instance (1) share clock and reset.
module tb_mouse_position_tracker;

   typedef struct {
      int x; int y; int btn; int chg; int ovf; int cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       pkt_valid [2];
   logic       pkt_ready [2];
   logic [7:0] pkt_status [2];
   logic [7:0] pkt_dx [2];
   logic [7:0] pkt_dy [2];
   logic       set_pos [2];
   logic [9:0] set_x [2];
   logic [9:0] set_y [2];
   logic [9:0] pos_x [2];
   logic [9:0] pos_y [2];
   logic [2:0] buttons [2];
   logic [2:0] btn_change [2];
   logic       pos_valid [2];
   logic [7:0] ovf_count [2];
`ifdef MOUSE_WHEEL_EN
   logic [3:0] pkt_dz [2];
   logic [7:0] wheel_pos [2];
`endif

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   mouse_position_tracker #(.WRAP(0)) u_dut (
      .CLK(clk), .RESET(rst_n), .PKT_VALID(pkt_valid[0]), .PKT_READY(pkt_ready[0]),
      .PKT_STATUS(pkt_status[0]), .PKT_DX(pkt_dx[0]), .PKT_DY(pkt_dy[0]),
`ifdef MOUSE_WHEEL_EN
      .PKT_DZ(pkt_dz[0]), .WHEEL_POS(wheel_pos[0]),
`endif
      .SET_POS(set_pos[0]), .SET_X(set_x[0]), .SET_Y(set_y[0]),
      .POS_X(pos_x[0]), .POS_Y(pos_y[0]), .BUTTONS(buttons[0]), .BTN_CHANGE(btn_change[0]),
      .POS_VALID(pos_valid[0]), .OVF_COUNT(ovf_count[0])
   );

   mouse_position_tracker #(.WRAP(1)) u_wrap (
      .CLK(clk), .RESET(rst_n), .PKT_VALID(pkt_valid[1]), .PKT_READY(pkt_ready[1]),
      .PKT_STATUS(pkt_status[1]), .PKT_DX(pkt_dx[1]), .PKT_DY(pkt_dy[1]),
`ifdef MOUSE_WHEEL_EN
      .PKT_DZ(pkt_dz[1]), .WHEEL_POS(wheel_pos[1]),
`endif
      .SET_POS(set_pos[1]), .SET_X(set_x[1]), .SET_Y(set_y[1]),
      .POS_X(pos_x[1]), .POS_Y(pos_y[1]), .BUTTONS(buttons[1]), .BTN_CHANGE(btn_change[1]),
      .POS_VALID(pos_valid[1]), .OVF_COUNT(ovf_count[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input int x, input int y, input int btn, input int chg,
                               input int ovf);
      exp_t e;
      e.x = x; e.y = y; e.btn = btn; e.chg = chg; e.ovf = ovf; e.cyc = 0;
      return e;
   endfunction

   task automatic push(input int d, input exp_t e);
      if (d == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic mon(input int d);
      exp_t e;
      string p;
      p = (d == 0) ? "clamp" : "wrap";
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL %s unexpected_pos_valid: got 1, expected 0 (t=%0t)", p, $time);
         return;
      end
      e = (d == 0) ? q0.pop_front() : q1.pop_front();
      chk({p, " pos_x"}, int'(pos_x[d]), e.x);
      chk({p, " pos_y"}, int'(pos_y[d]), e.y);
      chk({p, " buttons"}, int'(buttons[d]), e.btn);
      chk({p, " btn_change"}, int'(btn_change[d]), e.chg);
      chk({p, " ovf_count"}, int'(ovf_count[d]), e.ovf);
      chk({p, " latency_cycle"}, cyc, e.cyc);
   endtask

   always @(negedge clk) if (pos_valid[0] === 1'b1) mon(0);
   always @(negedge clk) if (pos_valid[1] === 1'b1) mon(1);

   task automatic wait_ready(input int d, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (pkt_ready[d] === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout dut%0d: got 0, expected 1", d);
      end
   endtask

   task automatic send(input int d, input logic [7:0] st, input logic [7:0] dx,
                       input logic [7:0] dy, input bit exp_on, input exp_t e);
      bit ok;
      wait_ready(d, ok);
      if (!ok) return;
      pkt_valid[d] = 1'b1; pkt_status[d] = st; pkt_dx[d] = dx; pkt_dy[d] = dy;
      @(posedge clk);
      e.cyc = cyc + 3;
      if (exp_on) push(d, e);
      @(negedge clk);
      pkt_valid[d] = 1'b0;
   endtask

   task automatic load(input int d, input int x, input int y, input exp_t e);
      bit ok;
      wait_ready(d, ok);
      if (!ok) return;
      set_pos[d] = 1'b1; set_x[d] = 10'(x); set_y[d] = 10'(y);
      @(posedge clk);
      e.cyc = cyc + 1;
      push(d, e);
      @(negedge clk);
      set_pos[d] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int x;
      int ovf;
      exp_t none;
      none = mk(0, 0, 0, 0, 0);
      for (int d = 0; d < 2; d++) begin
         pkt_valid[d] = 1'b0; pkt_status[d] = 8'h00; pkt_dx[d] = 8'h00; pkt_dy[d] = 8'h00;
         set_pos[d] = 1'b0; set_x[d] = 10'd0; set_y[d] = 10'd0;
`ifdef MOUSE_WHEEL_EN
         pkt_dz[d] = 4'h0;
`endif
      end

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset pos_x", int'(pos_x[0]), 320);
      chk("reset pos_y", int'(pos_y[0]), 240);
      chk("reset buttons", int'(buttons[0]), 0);
      chk("reset ovf_count", int'(ovf_count[0]), 0);
      chk("reset pkt_ready", int'(pkt_ready[0]), 1);
      chk("reset pos_valid", int'(pos_valid[0]), 0);

      // Basic move, left button press
      send(0, 8'h09, 8'h10, 8'h05, 1'b1, mk(336, 235, 1, 1, 0));

      // Forced position, negative move clamps X at 0, Y grows downward
      load(0, 5, 5, mk(5, 5, 1, 0, 0));
      send(0, 8'h38, 8'hF0, 8'hF0, 1'b1, mk(0, 21, 0, 1, 0));
      send(0, 8'h18, 8'h00, 8'h00, 1'b1, mk(0, 21, 0, 0, 0));

      // Overflow saturation and counter saturation
      load(0, 320, 240, mk(320, 240, 0, 0, 0));
      send(0, 8'h48, 8'h20, 8'h00, 1'b1, mk(575, 240, 0, 0, 1));
      x = 575;
      ovf = 1;
      for (int i = 0; i < 300; i++) begin
         x = (x + 255 > 639) ? 639 : x + 255;
         ovf = (ovf < 255) ? ovf + 1 : 255;
         send(0, 8'h48, 8'h20, 8'h00, 1'b1, mk(x, 240, 0, 0, ovf));
      end
      load(0, 1000, 1000, mk(639, 479, 0, 0, 255));

      // Wrapping instance: X wraps past right edge, Y wraps past top
      load(1, 630, 0, mk(630, 0, 0, 0, 0));
      send(1, 8'h08, 8'h14, 8'h00, 1'b1, mk(10, 0, 0, 0, 0));
      send(1, 8'h08, 8'h00, 8'h05, 1'b1, mk(10, 475, 0, 0, 0));
      send(1, 8'h10, 8'hF0, 8'h00, 1'b1, mk(634, 475, 0, 0, 0));

      // Reset during CALC discards the packet
      send(0, 8'h01, 8'h10, 8'h10, 1'b0, none);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_reset pkt_ready", int'(pkt_ready[0]), 1);
      chk("post_reset pos_x", int'(pos_x[0]), 320);
      chk("post_reset pos_y", int'(pos_y[0]), 240);
      chk("post_reset ovf_count", int'(ovf_count[0]), 0);
      chk("post_reset buttons", int'(buttons[0]), 0);
      repeat (6) @(negedge clk);
      chk("post_reset pos_valid", int'(pos_valid[0]), 0);

      for (int i = 0; i < 50 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
      chk("pending_expectations", q0.size() + q1.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
